// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the multi-cycle accumulator ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_XOR  = 4'd3,
    OP_COMP = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_ROL  = 4'd7,
    OP_ROR  = 4'd8,
    OP_MUL  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    MUL  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// hi/lo present the product as it will stand after the current iteration,
// so on the cycle done is high they carry the finished result.
module alu_mul_seq #(
  parameter int WORD_W = 10,
  parameter int CNT_W  = $clog2(WORD_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] mcand,
  input  logic [WORD_W-1:0] mplier,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);

  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   mcand_q;
  logic [WORD_W-1:0]   mplier_q;
  logic [2*WORD_W-1:0] prod;
  logic [WORD_W-1:0]   addend;
  logic [WORD_W:0]     sum;
  logic [2*WORD_W-1:0] prod_nxt;

  // One iteration: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right by one.
  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign sum      = {1'b0, prod[2*WORD_W-1:WORD_W]} + {1'b0, addend};
  assign prod_nxt = {sum, prod[WORD_W-1:1]};
  assign hi       = prod_nxt[2*WORD_W-1:WORD_W];
  assign lo       = prod_nxt[WORD_W-1:0];
  assign done     = busy && (cnt == CNT_W'(1));

  // Iteration counter and busy flag; reset aborts any product in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= CNT_W'(WORD_W);
      busy <= 1'b1;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  // Operand and partial-product datapath, loaded on start.
  always_ff @(posedge clock) begin
    if (start) begin
      mcand_q  <= mcand;
      mplier_q <= mplier;
      prod     <= '0;
    end else if (busy) begin
      prod     <= prod_nxt;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Accumulator ALU with N/Z/C/V flags, multi-cycle rotate and multiply,
// and an extension register holding the high word of products.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WORD_W = 10,
  parameter int OP_W   = 4,
  parameter int CNT_W  = $clog2(WORD_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_ACC,
  input  logic [OP_W-1:0]   alu_op,
  input  logic              ACC_bus,
  input  logic              EXT_bus,
  inout  wire  [WORD_W-1:0] sysbus,
  output logic              z_flag,
  output logic              n_flag,
  output logic              c_flag,
  output logic              v_flag,
  output logic              busy,
  output logic              done
);

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] ext;
  alu_state_t        state;
  logic [CNT_W-1:0]  rot_cnt;
  logic              rot_left;
  logic [WORD_W:0]   sum_w;
  logic [WORD_W:0]   diff_w;
  logic [WORD_W-1:0] rot_mod;
  logic [CNT_W-1:0]  rot_amt;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [WORD_W-1:0] mul_hi;
  logic [WORD_W-1:0] mul_lo;

  // Signed overflow: operands agree in sign and the result disagrees.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow on subtract: operands differ in sign and the result
  // takes the subtrahend's sign.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  assign sysbus = ACC_bus ? acc : (EXT_bus ? ext : 'z);
  assign z_flag = (acc == '0);
  assign n_flag = acc[WORD_W-1];

  // The extra top bit is carry-out for add and borrow (acc < bus) for subtract.
  assign sum_w   = {1'b0, acc} + {1'b0, sysbus};
  assign diff_w  = {1'b0, acc} - {1'b0, sysbus};
  assign rot_mod = sysbus % WORD_W'(WORD_W);
  assign rot_amt = CNT_W'(rot_mod);

  assign mul_start = (state == IDLE) && load_ACC && (alu_op == OP_W'(OP_MUL));

  alu_mul_seq #(
    .WORD_W(WORD_W),
    .CNT_W (CNT_W)
  ) u_mul (
    .clock (clock),
    .reset (reset),
    .start (mul_start),
    .mcand (sysbus),
    .mplier(acc),
    .busy  (mul_busy),
    .done  (mul_done),
    .hi    (mul_hi),
    .lo    (mul_lo)
  );

  // Sequencer FSM: executes single-cycle ops in IDLE, steps rotates and
  // collects the multiplier result, with registered flags and handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      ext      <= '0;
      c_flag   <= 1'b0;
      v_flag   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rot_cnt  <= '0;
      rot_left <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_ACC) begin
            done <= 1'b1;
            case (alu_op)
              OP_W'(OP_PASS): acc <= sysbus;
              OP_W'(OP_ADD): begin
                acc    <= sum_w[WORD_W-1:0];
                c_flag <= sum_w[WORD_W];
                v_flag <= add_ovf(acc[WORD_W-1], sysbus[WORD_W-1], sum_w[WORD_W-1]);
              end
              OP_W'(OP_SUB): begin
                acc    <= diff_w[WORD_W-1:0];
                c_flag <= diff_w[WORD_W];
                v_flag <= sub_ovf(acc[WORD_W-1], sysbus[WORD_W-1], diff_w[WORD_W-1]);
              end
              OP_W'(OP_XOR):  acc <= acc ^ sysbus;
              OP_W'(OP_COMP): acc <= ~acc;
              OP_W'(OP_AND):  acc <= acc & sysbus;
              OP_W'(OP_OR):   acc <= acc | sysbus;
              OP_W'(OP_ROL), OP_W'(OP_ROR): begin
                // A zero rotate amount completes immediately like any other op.
                if (rot_amt != '0) begin
                  state    <= ROT;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  rot_cnt  <= rot_amt;
                  rot_left <= (alu_op == OP_W'(OP_ROL));
                end
              end
              OP_W'(OP_MUL): begin
                state <= MUL;
                busy  <= 1'b1;
                done  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ROT: begin
          acc     <= rot_left ? {acc[WORD_W-2:0], acc[WORD_W-1]}
                              : {acc[0], acc[WORD_W-1:1]};
          rot_cnt <= rot_cnt - CNT_W'(1);
          if (rot_cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        MUL: begin
          if (mul_done) begin
            acc    <= mul_lo;
            ext    <= mul_hi;
            c_flag <= |mul_hi;
            v_flag <= 1'b0;
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (!mul_busy) begin
            // Multiplier idle without having finished: release the sequencer.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Next-generation accumulator ALU for the basic processor.
- Adds to the single-cycle accumulator ALU:
  - an encoded opcode input
  - full N/Z/C/V flags
  - AND/OR ops
  - multi-cycle rotate and multiply, with a busy/done handshake
  - an extension register (EXT) holding the high word of products
- Sits on the shared tri-state sysbus under sequencer control.

Parameters:
- WORD_W, 10, accumulator/bus width (>=4).
- OP_W, 4, opcode width (>=4).
- CNT_W, $clog2(WORD_W)+1, width of the internal iteration counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- load_ACC  input  1  accept strobe: execute alu_op with the current sysbus operand.
- alu_op  input  OP_W  operation code (alu_pkg encoding).
- ACC_bus  input  1  drive acc onto sysbus.
- EXT_bus  input  1  drive ext onto sysbus.
- sysbus  inout  WORD_W  shared system bus.
- z_flag  output  1  acc == 0 (combinational).
- n_flag  output  1  acc[WORD_W-1] (combinational).
- c_flag  output  1  registered carry/borrow/product-high flag.
- v_flag  output  1  registered signed-overflow flag.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - Reset forces acc=0, ext=0, c_flag=0, v_flag=0, busy=0, done=0, counter=0 and FSM=IDLE.
  - Reset mid-operation aborts the operation with no partial result retained.
- Bus drive:
  - sysbus = acc when ACC_bus, ext when EXT_bus, else high-Z.
  - ACC_bus and EXT_bus both high is illegal; the bench asserts against it.
- FSM states: IDLE, ROT, MUL.
  - load_ACC is honoured only in IDLE.
  - load_ACC while busy=1 is ignored with no state change.
- Single-cycle ops, executed in IDLE on the clock edge T where load_ACC=1:
  - PASS: acc<=sysbus.
  - ADD: acc<=acc+sysbus.
    - c = carry out.
    - v = signed overflow.
  - SUB: acc<=acc-sysbus.
    - c = borrow (acc<sysbus, unsigned).
    - v = signed overflow.
  - XOR, AND, OR: bitwise with sysbus.
  - COMP: acc<=~acc.
  - Flags: c and v are written only by ADD/SUB/MUL; all other ops hold them.
  - done=1 for the cycle following T. busy stays 0.
- ROL/ROR:
  - At T, latch k = sysbus mod WORD_W.
  - If k==0: behaves as a single-cycle op with acc unchanged.
  - Otherwise: FSM->ROT and busy=1 from T.
    - Each subsequent edge rotates acc by 1 bit and decrements the counter.
    - After edge T+k: busy=0, FSM=IDLE, and done=1 for that cycle.
  - Flags c and v are held.
- MUL (unsigned shift-add):
  - At T: multiplier<=acc, multiplicand<=sysbus, 2*WORD_W-bit product<=0, FSM->MUL, busy=1.
  - WORD_W iterations, one per edge.
  - At edge T+WORD_W: acc<=product low word, ext<=product high word, c=|high, v=0, busy=0, done=1 for that cycle.
- Intermediate visibility: acc and ext may show intermediate values while busy. Only results after done are architecturally valid.
- Opcode handling: undefined opcodes are NOPs; done still pulses.
- Combinational flags: z_flag and n_flag always track the current acc, including intermediate values.

Decomposition:
- alu_pkg holds:
  - typedef enum alu_op_t: PASS=0, ADD=1, SUB=2, XOR=3, COMP=4, AND=5, OR=6, ROL=7, ROR=8, MUL=9.
  - typedef enum alu_state_t: IDLE, ROT, MUL.
- One sub-module, alu_mul_seq:
  - Iterative shift-add multiplier with start/busy/done.
  - Parameter WORD_W; outputs hi and lo words.
  - alu_mc instantiates it and muxes its result into acc/ext.

Test Plan:
- ADD wrap (WORD_W=10): PASS 0x3FF, then ADD 0x001 -> acc=0x000, z=1, c=1, v=0, done one cycle after accept.
- SUB borrow and overflow:
  - PASS 5, SUB 7 -> acc=0x3FE, n=1, c=1, v=0.
  - PASS 0x1FF, ADD 1 -> acc=0x200, v=1, n=1.
- Rotate:
  - PASS 0x001, ROL sysbus=3 -> busy high 3 cycles, acc=0x008, single done pulse.
  - ROL sysbus=13 -> same as k=3.
  - ROR sysbus=0 -> acc unchanged, busy never asserts.
- MUL: PASS 25, MUL sysbus=50 -> busy 10 cycles, acc=0x0E2, ext=0x001, c=1. EXT_bus then drives 0x001 onto sysbus.
- Busy lockout: during MUL, pulse load_ACC with PASS 0x155 -> ignored; final acc still 0x0E2.
- Reset mid-MUL: assert reset at iteration 4 -> acc=0, ext=0, busy=0, done=0 immediately. After release, PASS 7 works normally.
